// File: rtl/tlc_multiphase_if.sv
// Sensor/lamp bundle for tlc_multiphase.
//   car         : level request per approach
//   preempt     : emergency preemption request (level)
//   preempt_dir : approach to preempt to; out-of-range values disable preempt
//   lights      : per approach {red, yellow, green}, approach i at bits [3i+2:3i]
//   dir         : approach currently or last served
//   phase       : 0 idle, 1 green, 2 yellow, 3 all-red
// master = controller side, slave = sensor/lamp side.
interface tlc_multiphase_if #(
  parameter int unsigned N_DIR = 3,
  parameter int unsigned DW    = 2
);
  logic [N_DIR-1:0]   car;
  logic               preempt;
  logic [DW-1:0]      preempt_dir;
  logic [3*N_DIR-1:0] lights;
  logic [DW-1:0]      dir;
  logic [1:0]         phase;

  modport master (
    input  car, preempt, preempt_dir,
    output lights, dir, phase
  );

  modport slave (
    output car, preempt, preempt_dir,
    input  lights, dir, phase
  );
endinterface

// File: rtl/tlc_multiphase.sv
// Multi-approach traffic-light controller: request latching, round-robin
// phase arbitration, gap-out/max-out green, yellow and all-red clearance,
// emergency preemption.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   bus : tlc_multiphase_if.master (car/preempt in, lights/dir/phase out)
module tlc_multiphase #(
  parameter int unsigned N_DIR     = 3,
  parameter int unsigned DW        = 2,
  parameter int unsigned TW        = 8,
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 16,
  parameter int unsigned YELLOW    = 3,
  parameter int unsigned ALLRED    = 1
) (
  input  logic              clk,
  input  logic              rst,
  tlc_multiphase_if.master  bus
);

  localparam int unsigned LW = 3 * N_DIR;
  localparam logic [LW-1:0] ALL_RED = {N_DIR{3'b100}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_ALLRED = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    dir_q, dir_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [N_DIR-1:0] pending_q, pending_d;
  logic [LW-1:0]    lights_q, lights_d;
  logic [1:0]       phase_q, phase_d;

  logic             pre_valid;
  logic [N_DIR-1:0] dir_oh;
  logic             others_pending;
  logic             car_dir;
  logic             enter_green;
  logic [DW-1:0]    rr_dir;

  // First pending approach after cur, wrapping; cur itself is tried last.
  function automatic logic [DW-1:0] rr_pick(input logic [N_DIR-1:0] req,
                                            input logic [DW-1:0]    cur);
    logic [DW-1:0] pick;
    logic          found;
    int unsigned   cand;
    pick  = cur;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_DIR; k++) begin
      cand = (32'(cur) + k) % N_DIR;
      if (!found && (|(req & (N_DIR'(1) << cand)))) begin
        pick  = DW'(cand);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Lamp pattern for a given state and served approach.
  function automatic logic [LW-1:0] lamps(input state_e st, input logic [DW-1:0] d);
    logic [LW-1:0] l;
    logic [2:0]    lamp;
    l = '0;
    for (int unsigned i = 0; i < N_DIR; i++) begin
      lamp = 3'b100;
      if (32'(d) == i) begin
        if (st == ST_GREEN) begin
          lamp = 3'b001;
        end else if (st == ST_YELLOW) begin
          lamp = 3'b010;
        end
      end
      l = l | (LW'(lamp) << (3 * i));
    end
    return l;
  endfunction

  // Request qualifiers derived from latched state and live inputs.
  always_comb begin
    pre_valid      = bus.preempt && (32'(bus.preempt_dir) < N_DIR);
    dir_oh         = N_DIR'(1) << dir_q;
    others_pending = |(pending_q & ~dir_oh);
    car_dir        = |(bus.car & dir_oh);
    rr_dir         = rr_pick(pending_q, dir_q);
  end

  // Next-state, timer, request latch and registered output decode.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    enter_green = 1'b0;
    timer_d     = (timer_q == '1) ? timer_q : timer_q + TW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (pre_valid) begin
          state_d     = ST_GREEN;
          dir_d       = bus.preempt_dir;
          enter_green = 1'b1;
        end else if (|pending_q) begin
          state_d     = ST_GREEN;
          dir_d       = rr_dir;
          enter_green = 1'b1;
        end
      end
      ST_GREEN: begin
        if (pre_valid && (bus.preempt_dir == dir_q)) begin
          // Preempt held on the served approach freezes the green timer.
          timer_d = timer_q;
        end else if (pre_valid) begin
          state_d = ST_YELLOW;
        end else if (others_pending &&
                     (((timer_q >= TW'(GREEN_MIN - 1)) && !car_dir) ||
                      (timer_q >= TW'(GREEN_MAX - 1)))) begin
          state_d = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (timer_q >= TW'(YELLOW - 1)) begin
          state_d = ST_ALLRED;
        end
      end
      ST_ALLRED: begin
        if (timer_q >= TW'(ALLRED - 1)) begin
          if (pre_valid) begin
            state_d     = ST_GREEN;
            dir_d       = bus.preempt_dir;
            enter_green = 1'b1;
          end else if (|pending_q) begin
            state_d     = ST_GREEN;
            dir_d       = rr_dir;
            enter_green = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end

    // New requests latch except on the approach being granted this edge.
    pending_d = (pending_q | bus.car) &
                ~(enter_green ? (N_DIR'(1) << dir_d) : N_DIR'(0));

    lights_d = lamps(state_d, dir_d);
    phase_d  = state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= '0;
      timer_q   <= '0;
      pending_q <= '0;
      lights_q  <= ALL_RED;
      phase_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      lights_q  <= lights_d;
      phase_q   <= phase_d;
    end
  end

  assign bus.lights = lights_q;
  assign bus.dir    = dir_q;
  assign bus.phase  = phase_q;

endmodule

// File: doc/tlc_multiphase.md
# tlc_multiphase

Parametrised traffic-light controller serving `N_DIR` approaches from one clock. It combines request latching, round-robin phase arbitration and light decoding in a single block. Relative to the fixed three-direction master/combiner pair, it adds:
- configurable phase timing,
- gap-out/max-out green extension,
- a clearance all-red interval,
- an emergency preemption input.

It sits between the car sensors and the lamp drivers.

## Interface
- `N_DIR`, 3: number of approaches (2..8).
- `DW`, 2: width of direction index; must satisfy 2^DW >= N_DIR.
- `TW`, 8: phase timer width; must hold `GREEN_MAX`.
- `GREEN_MIN`, 4: minimum green cycles (>=1).
- `GREEN_MAX`, 16: maximum green cycles when others wait (>=`GREEN_MIN`).
- `YELLOW`, 3: yellow cycles (>=1).
- `ALLRED`, 1: all-red clearance cycles (>=1).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low (asserted at 0).
- `car`  in  `N_DIR`  level request per approach.
- `preempt`  in  1  emergency preemption request, level.
- `preempt_dir`  in  `DW`  approach to preempt to; values >= `N_DIR` make `preempt` ignored.
- `lights`  out  `3*N_DIR`  per approach i: bit 3i+2 red, 3i+1 yellow, 3i green; exactly one bit set per approach.
- `dir`  out  `DW`  approach currently or last served.
- `phase`  out  2  0 IDLE, 1 GREEN, 2 YELLOW, 3 ALLRED.

## Operation
- Reset (`rst`=0, async) values:
  - state IDLE, `phase`=0, `dir`=0, timer=0.
  - `pending`=0, preempt latch clear.
  - `lights` all red (default: 9'b100100100).
- `pending[i]` is set on any edge where `car[i]`=1. It is cleared on the edge that enters GREEN for i. Set wins over clear only if i is not the direction entering GREEN.
- Timer: cleared on every state entry. Otherwise it increments each cycle, saturating at 2^TW-1.
- Round-robin: the next direction is the first pending index searched from (`dir`+1) mod `N_DIR` upward with wrap-around. `dir` itself is searched last.
- IDLE: all red. Transitions:
  - valid `preempt` -> GREEN on `preempt_dir`.
  - else any `pending` -> GREEN on the round-robin pick.
  - else stay.
- GREEN: approach `dir` green, all others red. "Others pending" = any `pending[j]`, j != `dir`.
  - Valid `preempt` with `preempt_dir`=`dir`: stay; timer holds.
  - Valid `preempt` with `preempt_dir`!=`dir`: -> YELLOW immediately, ignoring `GREEN_MIN`.
  - Others pending and ((timer >= `GREEN_MIN`-1 and `car[dir]`=0) or timer >= `GREEN_MAX`-1): -> YELLOW (gap-out / max-out).
  - No other pending: rest in green indefinitely.
- YELLOW: approach `dir` yellow. After `YELLOW` cycles -> ALLRED. Preempt does not shorten it.
- ALLRED: all red. After `ALLRED` cycles:
  - valid `preempt` -> GREEN on `preempt_dir`.
  - else pending -> GREEN on the round-robin pick.
  - else -> IDLE.
- `dir` updates only on the edge that enters GREEN.
- `lights` and `phase` are registered from state and `dir`; they are never decoded combinationally from inputs.

## Timing
- Request to green from IDLE: `car[i]` high at edge k -> `pending` set at k; IDLE sees it and enters GREEN at edge k+1. `lights` show green from k+1.
- GREEN lasts at least `GREEN_MIN` cycles except under preemption. With others pending it lasts at most `GREEN_MAX` cycles.
- YELLOW lasts exactly `YELLOW` cycles and ALLRED exactly `ALLRED` cycles, with no extra idle cycle between phases.
- Changeover with defaults: the last green cycle is followed by 3 yellow, 1 all-red, then the next green.
- Preemption reaction from a conflicting green: 1 cycle to YELLOW, then `YELLOW`+`ALLRED` cycles before the preempt green.
- Preempt deasserted while in preempt green: normal GREEN rules resume with timer continuing.
- Simultaneous requests are resolved by round-robin order, never by fixed priority.
- Reset mid-phase: all outputs return to reset values asynchronously. Pending requests are discarded.

## Test plan
- Reset, `car`=0 for 20 cycles -> `lights`=9'b100100100, `phase`=0 throughout.
- `car`=3'b001 one cycle -> next edge `phase`=1, `dir`=0, `lights`=9'b100100001. Green holds for 50 cycles with no other request.
- Green on 0 with `car[0]` held 1, `car[1]` raised -> green exactly 16 cycles (max-out). Then 3 cycles of `lights`=9'b100100010, 1 cycle all red, then `lights`=9'b100001100, `dir`=1.
- `car`=3'b111 together from IDLE after `dir`=1 -> service order 2, 0, 1. Each green is 4 cycles when its car drops after the first cycle.
- Green on 0 at timer=1, `preempt`=1, `preempt_dir`=2 -> YELLOW next edge; green on 2 after 3+1 cycles; held while `preempt`=1. `preempt_dir`=3 with `N_DIR`=3 has no effect.
- `rst` pulled low mid-YELLOW between edges -> `lights` all red and `phase`=0 immediately. After release, prior `pending` is not served.
